// File: rtl/initiator_port.sv
// Bus-side serialiser/deserialiser for the initiator.
// Captures address and write data at grant and shifts them onto the 1-bit bus
// LSB first. Assembles serial read data into bytes. Passes the request, grant,
// ack and split handshakes straight through.
module initiator_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  input  logic [ADDR_WIDTH-1:0] init_addr_in,
  input  logic                  init_addr_in_valid,
  input  logic [DATA_WIDTH-1:0] init_data_in,
  input  logic                  init_data_in_valid,
  input  logic                  init_rw,
  output logic                  init_grant,
  output logic                  init_ack,
  output logic                  init_split_ack,
  output logic [DATA_WIDTH-1:0] init_data_out,
  output logic                  init_data_out_valid,
  output logic                  bus_req,
  input  logic                  bus_grant,
  input  logic                  bus_ack,
  input  logic                  bus_split,
  output logic                  bus_out,
  output logic                  bus_out_valid,
  output logic                  bus_mode,
  output logic                  bus_rw,
  input  logic                  bus_in,
  input  logic                  bus_in_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } tx_state_e;

  // The TX counter holds the number of bits already driven in the current phase.
  localparam int CNT_W       = $clog2(ADDR_WIDTH + 1);
  localparam int RX_CNT_W    = $clog2(DATA_WIDTH);
  // Write data may trail the address by up to this many cycles.
  localparam int LATE_WINDOW = 8;

  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LATE_LAST = CNT_W'(LATE_WINDOW);
  localparam logic [RX_CNT_W-1:0] RX_LAST   = RX_CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  has_data_q;
  logic                  bus_out_q;
  logic                  bus_out_valid_q;
  logic                  bus_mode_q;
  logic                  bus_rw_q;

  logic [DATA_WIDTH-2:0] rx_sh_q;
  logic [RX_CNT_W-1:0]   rx_cnt_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;

  logic capture;
  logic frame_stop;
  logic late_data;

  // Handshakes are pure wires between initiator and bus.
  assign bus_req        = init_req;
  assign init_grant     = bus_grant;
  assign init_ack       = bus_ack;
  assign init_split_ack = bus_split;

  assign bus_out             = bus_out_q;
  assign bus_out_valid       = bus_out_valid_q;
  assign bus_mode            = bus_mode_q;
  assign bus_rw              = bus_rw_q;
  assign init_data_out       = rx_data_q;
  assign init_data_out_valid = rx_valid_q;

  // Frame control decisions: capture, late write data, and end/abort of a frame.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    capture    = 1'b0;
    frame_stop = 1'b0;
    late_data  = 1'b0;
    case (state_q)
      IDLE: capture = bus_grant && init_addr_in_valid;
      ADDR: begin
        // Lost grant aborts; a read (or write with no data) ends after the address.
        frame_stop = !bus_grant || (tx_cnt_q == ADDR_LAST && !has_data_q);
        late_data  = bus_grant && bus_rw_q && !has_data_q && init_data_in_valid &&
                     (tx_cnt_q <= LATE_LAST);
      end
      // The last data bit is already on the wire, so it completes even if grant drops.
      DATA:    frame_stop = !bus_grant || (tx_cnt_q == DATA_LAST);
      default: frame_stop = 1'b1;
    endcase
  end

  // TX FSM: IDLE -> ADDR -> DATA -> IDLE with registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the address/data shift registers are reset too, so no stale frame
    // contents survive a reset.
    if (!rst_n) begin
      state_q         <= IDLE;
      tx_cnt_q        <= '0;
      addr_sh_q       <= '0;
      data_q          <= '0;
      has_data_q      <= 1'b0;
      bus_out_q       <= 1'b0;
      bus_out_valid_q <= 1'b0;
      bus_mode_q      <= 1'b0;
      bus_rw_q        <= 1'b0;
    end else if (frame_stop) begin
      state_q         <= IDLE;
      tx_cnt_q        <= '0;
      has_data_q      <= 1'b0;
      bus_out_q       <= 1'b0;
      bus_out_valid_q <= 1'b0;
      bus_mode_q      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q         <= ADDR;
            tx_cnt_q        <= CNT_W'(1);
            addr_sh_q       <= init_addr_in >> 1;
            bus_out_q       <= init_addr_in[0];
            bus_out_valid_q <= 1'b1;
            bus_mode_q      <= 1'b0;
            bus_rw_q        <= init_rw;
            has_data_q      <= init_rw && init_data_in_valid;
            if (init_rw && init_data_in_valid) begin
              data_q <= init_data_in;
            end
          end
        end
        ADDR: begin
          if (tx_cnt_q == ADDR_LAST) begin
            // Only reached with data pending; reads stop via frame_stop.
            state_q    <= DATA;
            tx_cnt_q   <= CNT_W'(1);
            bus_out_q  <= data_q[0];
            data_q     <= data_q >> 1;
            bus_mode_q <= 1'b1;
          end else begin
            bus_out_q <= addr_sh_q[0];
            addr_sh_q <= addr_sh_q >> 1;
            tx_cnt_q  <= tx_cnt_q + CNT_W'(1);
            if (late_data) begin
              data_q     <= init_data_in;
              has_data_q <= 1'b1;
            end
          end
        end
        DATA: begin
          bus_out_q <= data_q[0];
          data_q    <= data_q >> 1;
          tx_cnt_q  <= tx_cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RX: shift serial bits in LSB first and publish each completed byte for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (bus_in_valid) begin
        if (rx_cnt_q == RX_LAST) begin
          rx_data_q  <= {bus_in, rx_sh_q};
          rx_valid_q <= 1'b1;
          rx_cnt_q   <= '0;
        end else begin
          rx_sh_q  <= {bus_in, rx_sh_q[DATA_WIDTH-2:1]};
          rx_cnt_q <= rx_cnt_q + RX_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_initiator_port.sv
// Self-checking bench for initiator_port: pass-through table, directed frame
// sequences, and randomized frames/RX traffic against a frame-level model.
module tb_initiator_port;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req;
  logic [AW-1:0] init_addr_in;
  logic          init_addr_in_valid;
  logic [DW-1:0] init_data_in;
  logic          init_data_in_valid;
  logic          init_rw;
  logic          init_grant;
  logic          init_ack;
  logic          init_split_ack;
  logic [DW-1:0] init_data_out;
  logic          init_data_out_valid;
  logic          bus_req;
  logic          bus_grant;
  logic          bus_ack;
  logic          bus_split;
  logic          bus_out;
  logic          bus_out_valid;
  logic          bus_mode;
  logic          bus_rw;
  logic          bus_in;
  logic          bus_in_valid;

  int n_vec = 0;
  int n_err = 0;

  // RX reference: bits collected so far and the last completed byte.
  logic          rx_bits[$];
  logic [DW-1:0] rx_last_byte;
  bit            rx_rand = 1'b0;

  typedef struct {
    logic       req;
    logic       grant;
    logic       ack;
    logic       split;
    logic [3:0] exp;   // {bus_req, init_grant, init_ack, init_split_ack}
  } pt_vec_t;

  initiator_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_req            (init_req),
    .init_addr_in        (init_addr_in),
    .init_addr_in_valid  (init_addr_in_valid),
    .init_data_in        (init_data_in),
    .init_data_in_valid  (init_data_in_valid),
    .init_rw             (init_rw),
    .init_grant          (init_grant),
    .init_ack            (init_ack),
    .init_split_ack      (init_split_ack),
    .init_data_out       (init_data_out),
    .init_data_out_valid (init_data_out_valid),
    .bus_req             (bus_req),
    .bus_grant           (bus_grant),
    .bus_ack             (bus_ack),
    .bus_split           (bus_split),
    .bus_out             (bus_out),
    .bus_out_valid       (bus_out_valid),
    .bus_mode            (bus_mode),
    .bus_rw              (bus_rw),
    .bus_in              (bus_in),
    .bus_in_valid        (bus_in_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rx_model_reset();
    rx_bits.delete();
    rx_last_byte = '0;
  endtask

  // One clock: optionally randomize RX, advance the RX model, sample after the edge.
  task automatic tick();
    bit pulse;
    pulse = 1'b0;
    if (rx_rand) begin
      bus_in_valid = ($urandom_range(0, 2) != 0);
      bus_in       = 1'($urandom_range(0, 1));
    end
    if (bus_in_valid === 1'b1) begin
      rx_bits.push_back(bus_in);
      if (rx_bits.size() == DW) begin
        for (int i = 0; i < DW; i++) rx_last_byte[i] = rx_bits[i];
        rx_bits.delete();
        pulse = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("rx_valid", init_data_out_valid, pulse);
    check("rx_data", init_data_out, rx_last_byte);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_out"}, bus_out, 1'b0);
    check({tag, "_bus_out_valid"}, bus_out_valid, 1'b0);
    check({tag, "_bus_mode"}, bus_mode, 1'b0);
    check({tag, "_bus_rw"}, bus_rw, 1'b0);
    check({tag, "_data_out"}, init_data_out, '0);
    check({tag, "_data_out_valid"}, init_data_out_valid, 1'b0);
  endtask

  // Present one request and follow the whole frame bit by bit.
  // delay: cycle offset of write-data valid after the address (-1 = never).
  // abort_at: bit index during which grant is dropped (-1 = never).
  // reset_at: bit index during which rst_n is pulsed (-1 = never).
  task automatic run_frame(input logic [AW-1:0] addr, input logic rw, input logic [DW-1:0] data,
                           input int delay, input int abort_at, input int reset_at);
    bit   has_data_exp;
    int   n;
    logic exp_bit;
    logic exp_mode;
    has_data_exp       = rw && (delay >= 0) && (delay <= 8);
    n                  = AW + (has_data_exp ? DW : 0);
    bus_grant          = 1'b1;
    init_addr_in       = addr;
    init_addr_in_valid = 1'b1;
    init_rw            = rw;
    init_data_in       = (delay == 0) ? data : DW'($urandom);
    init_data_in_valid = (delay == 0);
    tick();
    for (int i = 0; i < n; i++) begin
      exp_bit  = (i < AW) ? addr[i] : data[i-AW];
      exp_mode = (i >= AW);
      check("tx_valid", bus_out_valid, 1'b1);
      check("tx_bit", bus_out, exp_bit);
      check("tx_mode", bus_mode, exp_mode);
      check("tx_rw", bus_rw, rw);
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        rx_model_reset();
        check_all_zero("midreset");
        bus_grant          = 1'b0;
        init_addr_in_valid = 1'b0;
        init_data_in_valid = 1'b0;
        #1 rst_n = 1'b1;
        return;
      end
      // Address valids and post-capture data valids must be ignored mid-frame.
      init_addr_in_valid = 1'($urandom_range(0, 1));
      init_addr_in       = AW'($urandom);
      if (i + 1 == delay) begin
        init_data_in_valid = 1'b1;
        init_data_in       = data;
      end else begin
        init_data_in_valid = has_data_exp && (i + 1 > delay) && ($urandom_range(0, 1) == 1);
        init_data_in       = DW'($urandom);
      end
      if (i == abort_at) bus_grant = 1'b0;
      tick();
      if (i == abort_at) begin
        check("abort_valid", bus_out_valid, 1'b0);
        init_addr_in_valid = 1'b0;
        init_data_in_valid = 1'b0;
        return;
      end
    end
    check("frame_end_valid", bus_out_valid, 1'b0);
    bus_grant          = 1'b0;
    init_addr_in_valid = 1'b0;
    init_data_in_valid = 1'b0;
  endtask

  task automatic feed_rx_byte(input logic [DW-1:0] b);
    for (int i = 0; i < DW; i++) begin
      bus_in_valid = 1'b1;
      bus_in       = b[i];
      tick();
    end
    bus_in_valid = 1'b0;
  endtask

  initial begin
    pt_vec_t       tbl[8];
    int            pulses;
    logic [DW-1:0] gap_byte;
    logic [3:0]    pt_act;

    tbl = '{
      '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000},
      '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0100},
      '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010},
      '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0001},
      '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1100},
      '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0111},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1111}
    };

    rst_n              = 1'b0;
    init_req           = 1'b0;
    init_addr_in       = '0;
    init_addr_in_valid = 1'b0;
    init_data_in       = '0;
    init_data_in_valid = 1'b0;
    init_rw            = 1'b0;
    bus_grant          = 1'b0;
    bus_ack            = 1'b0;
    bus_split          = 1'b0;
    bus_in             = 1'b0;
    bus_in_valid       = 1'b0;
    rx_model_reset();

    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Combinational pass-through table (no address valid, so nothing is captured).
    for (int i = 0; i < 8; i++) begin
      init_req  = tbl[i].req;
      bus_grant = tbl[i].grant;
      bus_ack   = tbl[i].ack;
      bus_split = tbl[i].split;
      #1;
      pt_act = {bus_req, init_grant, init_ack, init_split_ack};
      check("passthru", pt_act, tbl[i].exp);
    end
    init_req  = 1'b0;
    bus_grant = 1'b0;
    bus_ack   = 1'b0;
    bus_split = 1'b0;
    tick();

    // Write with data in the capture cycle.
    run_frame(16'h0012, 1'b1, 8'hAA, 0, -1, -1);
    tick();

    // Read: address only, then a read byte arrives serially.
    run_frame(16'h0034, 1'b0, 8'h00, -1, -1, -1);
    feed_rx_byte(8'h5A);
    check("rd_byte", init_data_out, 8'h5A);
    tick();

    // Late write data at offsets 3, 8 (last accepted) and 9 (ignored).
    run_frame(16'h0056, 1'b1, 8'hAB, 3, -1, -1);
    run_frame(16'h8001, 1'b1, 8'h3C, 8, -1, -1);
    run_frame(16'h4002, 1'b1, 8'hC5, 9, -1, -1);
    // Read with a data valid in the capture cycle must not send data.
    run_frame(16'h0099, 1'b0, 8'hEE, 0, -1, -1);

    // Grant drop at address bit 7, then a clean restart.
    run_frame(16'h1234, 1'b1, 8'h0F, 0, 7, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_abort_idle", bus_out_valid, 1'b0);
    end
    run_frame(16'h1234, 1'b1, 8'h0F, 0, -1, -1);
    // Grant drop on the last data bit still ends cleanly.
    run_frame(16'hF00D, 1'b1, 8'h81, 0, AW + DW - 1, -1);

    // RX with gaps: valid every other cycle.
    gap_byte = 8'hC3;
    pulses   = 0;
    for (int i = 0; i < 2 * DW; i++) begin
      bus_in_valid = (i % 2 == 0);
      bus_in       = (i % 2 == 0) ? gap_byte[i/2] : 1'($urandom_range(0, 1));
      tick();
      if (init_data_out_valid === 1'b1) pulses++;
    end
    bus_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (init_data_out_valid === 1'b1) pulses++;
    end
    check("gap_pulses", pulses, 1);
    check("gap_byte", init_data_out, 8'hC3);

    // Reset in data bit 4, then no bits until a new capture.
    run_frame(16'h00FF, 1'b1, 8'h77, 0, -1, AW + 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_idle", bus_out_valid, 1'b0);
    end
    run_frame(16'h5A5A, 1'b1, 8'h96, 0, -1, -1);

    // Randomized frames with concurrent random RX traffic.
    rx_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int gap;
      int dly;
      int abt;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus_grant = 1'($urandom_range(0, 1));
        tick();
        check("rand_idle", bus_out_valid, 1'b0);
      end
      dly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 10);
      abt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, AW + DW - 1) : -1;
      run_frame(AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), dly, abt, -1);
    end
    rx_rand      = 1'b0;
    bus_in_valid = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
